// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory / dump arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry {addr,data} FIFO that buffers RAM read returns for the dump port.
module dump_skid_fifo #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_data [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr[0] <= '0;
      r_addr[1] <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (i_push) begin
        r_addr[r_wptr] <= i_push_addr;
        r_data[r_wptr] <= i_push_data;
        r_wptr         <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_addr  = r_addr[r_rptr];
  assign o_data  = r_data[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and an end-of-run dump engine.
// Optional DMEM_DUMP_CHECKSUM_EN adds dump_csum, the running sum of popped dump words.
module dmem_dump_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 512,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_d,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic [31:0]       run_cycles
`ifdef DMEM_DUMP_CHECKSUM_EN
  ,
  output logic [31:0]       dump_csum
`endif
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0]   DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [DC_W-1:0]   r_drain_cnt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_all;
  logic              r_rd_pend;
  logic [31:0]       r_run_cycles;

  logic              w_issue;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_occ;

  dump_skid_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_rd_pend),
    .i_push_addr (r_rd_addr),
    .i_push_data (mem_rdata),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_addr      (dump_addr),
    .o_data      (dump_data),
    .o_count     (w_fifo_count)
  );

  assign dump_valid = w_fifo_valid;
  assign w_pop      = w_fifo_valid & dump_ready;

  // Occupancy the FIFO will reach once the in-flight read lands and this cycle's pop retires.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b0, r_rd_pend} - {2'b0, w_pop};
  assign w_issue = (r_state == ST_DUMP) && !r_rd_all && (w_occ <= 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_stall = 1'b0;
    dump_done = 1'b0;
    case (r_state)
      ST_RUN: begin
        mem_en    = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (instr_d == HALT_INSTR) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        mem_en    = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (r_drain_cnt == '0) begin
          w_next = ST_DUMP;
        end
      end
      ST_DUMP: begin
        cpu_stall = 1'b1;
        mem_en    = w_issue;
        mem_addr  = r_rd_ptr;
        if (w_pop && (dump_addr == LAST_ADDR)) begin
          w_next = ST_DONE;
        end
      end
      default: begin
        cpu_stall = 1'b1;
        dump_done = 1'b1;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt  <= DRAIN_LOAD;
      r_run_cycles <= '0;
    end else begin
      if (r_state == ST_RUN) begin
        r_drain_cnt <= DRAIN_LOAD;
        if (r_run_cycles != 32'hFFFF_FFFF) begin
          r_run_cycles <= r_run_cycles + 32'd1;
        end
      end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
    end
  end

  assign run_cycles = r_run_cycles;

  // The pointer parks on the last address; r_rd_all blocks any further reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_rd_addr <= '0;
      r_rd_all  <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_ptr;
        if (r_rd_ptr == LAST_ADDR) begin
          r_rd_all <= 1'b1;
        end else begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum + 32'(dump_data);
    end
  end

  assign dump_csum = r_csum;
`endif

endmodule
